multu_hilo: RTL and testbench

MULTU_HILO -- requirements
Module: multu_hilo

---
 rtl/multu_hilo_pkg.sv | 21 ++
 rtl/mult_adder.sv | 13 +
 rtl/multu_hilo.sv | 84 ++++++++
 tb/tb_multu_hilo.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/multu_hilo_pkg.sv
// Shared ALU package: function codes used by the ALU result mux and the
// HI/LO multiply unit, plus the multiply sequencer state encoding.
package multu_hilo_pkg;

    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_SLT   = 6'b101010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mult_adder.sv
// WIDTH-bit unsigned adder with carry-out, used for the shift-add multiply step.
module mult_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/multu_hilo.sv
// Sequential unsigned multiplier (one shift-add step per cycle) that writes
// its 2*WIDTH-bit product into the HI/LO result registers.
module multu_hilo
    import multu_hilo_pkg::*;
#(
    parameter int         WIDTH    = 32,
    parameter logic [5:0] MULTU_OP = 6'b011001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mul_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    assign addend = prod[0] ? mcand : '0;

    mult_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (prod[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
            HiOut <= '0;
            LoOut <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Signal == MULTU_OP) begin
                        mcand <= dataA;
                        prod  <= {{WIDTH{1'b0}}, dataB};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Carry from the add becomes the new MSB as the product shifts right.
                    prod <= {add_cout, add_sum, prod[WIDTH-1:1]};
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    HiOut <= prod[2*WIDTH-1:WIDTH];
                    LoOut <= prod[WIDTH-1:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multu_hilo.sv
// Directed bench for multu_hilo: table of products plus hand-written
// sequences for level-sensitive restart, reset abort and reset priority.
module tb_multu_hilo;
    import multu_hilo_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] dataA, dataB;
    logic [5:0]   Signal;
    logic [W-1:0] HiOut, LoOut;
    logic         busy, done;

    int checks = 0;
    int errors = 0;

    multu_hilo #(.WIDTH(W), .MULTU_OP(6'b011001)) dut (
        .clk    (clk),
        .reset  (reset),
        .dataA  (dataA),
        .dataB  (dataB),
        .Signal (Signal),
        .HiOut  (HiOut),
        .LoOut  (LoOut),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    vec_t         vecs [8];
    logic [W-1:0] prev_hi, prev_lo;
    int           pulses;

    initial begin
        vecs[0] = '{32'd3,        32'd5,        32'h00000000, 32'h0000000F};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{32'h80000000, 32'd2,        32'h00000001, 32'h00000000};
        vecs[3] = '{32'd7,        32'd9,        32'h00000000, 32'h0000003F};
        vecs[4] = '{32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000};
        vecs[5] = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[6] = '{32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        vecs[7] = '{32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        reset  = 1'b0;
        dataA  = '0;
        dataB  = '0;
        Signal = OP_ADD;
        tick();
        tick();
        check("reset_hi",   64'(HiOut), 64'h0);
        check("reset_lo",   64'(LoOut), 64'h0);
        check("reset_busy", 64'(busy),  64'h0);
        check("reset_done", 64'(done),  64'h0);
        reset = 1'b1;
        tick();

        prev_hi = '0;
        prev_lo = '0;
        for (int v = 0; v < 8; v++) begin
            dataA  = vecs[v].a;
            dataB  = vecs[v].b;
            Signal = OP_MULTU;
            tick();
            Signal = OP_MFHI;
            check($sformatf("v%0d_busy_start", v), 64'(busy), 64'h1);
            check($sformatf("v%0d_hold_hi", v), 64'(HiOut), 64'(prev_hi));
            check($sformatf("v%0d_hold_lo", v), 64'(LoOut), 64'(prev_lo));
            pulses = 0;
            for (int i = 1; i <= W; i++) begin
                tick();
                if (done) pulses++;
                // Mid-run restart attempt with new operands must be ignored.
                if (i == 10) begin
                    Signal = OP_MULTU;
                    dataA  = 32'hA5A5A5A5;
                    dataB  = 32'h5A5A5A5A;
                end else if (i == 11) begin
                    Signal = OP_MFLO;
                end
                if (i == 20) begin
                    check($sformatf("v%0d_run_hi", v), 64'(HiOut), 64'(prev_hi));
                    check($sformatf("v%0d_run_lo", v), 64'(LoOut), 64'(prev_lo));
                    check($sformatf("v%0d_run_busy", v), 64'(busy), 64'h1);
                end
            end
            check($sformatf("v%0d_early_done", v), 64'(pulses), 64'h0);
            tick();
            check($sformatf("v%0d_done", v), 64'(done),  64'h1);
            check($sformatf("v%0d_busy_end", v), 64'(busy), 64'h0);
            check($sformatf("v%0d_hi", v), 64'(HiOut), 64'(vecs[v].hi));
            check($sformatf("v%0d_lo", v), 64'(LoOut), 64'(vecs[v].lo));
            tick();
            check($sformatf("v%0d_done_once", v), 64'(done), 64'h0);
            check($sformatf("v%0d_idle", v), 64'(busy), 64'h0);
            prev_hi = vecs[v].hi;
            prev_lo = vecs[v].lo;
        end

        // Level-sensitive start: Signal held high restarts on the first IDLE cycle.
        dataA  = 32'd2;
        dataB  = 32'd3;
        Signal = OP_MULTU;
        tick();
        for (int i = 1; i <= W; i++) tick();
        tick();
        check("lvl_done1", 64'(done),  64'h1);
        check("lvl_lo1",   64'(LoOut), 64'd6);
        tick();
        check("lvl_restart_busy", 64'(busy), 64'h1);
        Signal = OP_ADD;
        for (int i = 1; i <= W; i++) tick();
        tick();
        check("lvl_done2", 64'(done),  64'h1);
        check("lvl_lo2",   64'(LoOut), 64'd6);
        tick();
        check("lvl_no_third", 64'(busy), 64'h0);

        // Reset during RUN aborts without writing a partial result.
        dataA  = 32'h12345678;
        dataB  = 32'h9ABCDEF0;
        Signal = OP_MULTU;
        tick();
        Signal = OP_ADD;
        for (int i = 1; i <= 9; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_hi",   64'(HiOut), 64'h0);
        check("abort_lo",   64'(LoOut), 64'h0);
        check("abort_busy", 64'(busy),  64'h0);
        pulses = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (done) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'h0);

        // Reset wins over a simultaneous start.
        Signal = OP_MULTU;
        reset  = 1'b0;
        tick();
        check("rst_prio_busy", 64'(busy), 64'h0);
        reset  = 1'b1;
        Signal = OP_ADD;
        tick();
        check("rst_prio_idle", 64'(busy), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
